// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO for the PCS RX path: storage, wrap-bit pointers, occupancy, thresholds,
// sticky error flags and a registered read port. Define FIFO_PARITY_EN to add per-word even parity.
module sync_fifo_buf #(
  parameter int DATASIZE      = 72,
  parameter int ADDRSIZE      = 7,
  parameter int AFULL_THRESH  = 120,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
`ifdef FIFO_PARITY_EN
  ,
  output logic                par_err
`endif
);

  localparam int DEPTH = 1 << ADDRSIZE;
`ifdef FIFO_PARITY_EN
  localparam int MEMW = DATASIZE + 1;
`else
  localparam int MEMW = DATASIZE;
`endif

  // Thresholds are compared at the full count width so DEPTH itself is representable.
  localparam logic [ADDRSIZE:0] FULL_CNT   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_CNT  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_CNT = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [MEMW-1:0]     mem_q [DEPTH];
  logic [ADDRSIZE:0]   wptr_q, wptr_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [ADDRSIZE:0]   count_w;
  logic                full_w, empty_w;
  logic                wr_acc, rd_acc;
  logic [MEMW-1:0]     wr_word, rd_word;

  // Status decodes depend only on registered pointers, never on winc/rinc.
  assign count_w = wptr_q - rptr_q;
  assign full_w  = (count_w == FULL_CNT);
  assign empty_w = (count_w == '0);

  assign wr_acc = winc && !full_w;
  assign rd_acc = rinc && !empty_w;

`ifdef FIFO_PARITY_EN
  assign wr_word = {^wdata, wdata};
`else
  assign wr_word = wdata;
`endif
  assign rd_word = mem_q[rptr_q[ADDRSIZE-1:0]];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) begin
      rptr_d   = rptr_q + 1'b1;
      rdata_d  = rd_word[DATASIZE-1:0];
      rvalid_d = 1'b1;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (winc && full_w)  overflow_d  = 1'b1;
    if (rinc && empty_w) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers already discards its contents logically.
  always_ff @(posedge wclk) begin
    if (wr_acc) mem_q[wptr_q[ADDRSIZE-1:0]] <= wr_word;
  end

`ifdef FIFO_PARITY_EN
  logic rpar_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)     rpar_q <= 1'b0;
    else if (rd_acc) rpar_q <= rd_word[DATASIZE];
  end

  // Checked on the registered word, so the error lines up with rvalid without extra latency.
  assign par_err = rvalid_q && ((^rdata_q) != rpar_q);
`endif

  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign wfull         = full_w;
  assign rempty        = empty_w;
  assign walmost_full  = (count_w >= AFULL_CNT);
  assign ralmost_empty = (count_w <= AEMPTY_CNT);
  assign count         = count_w;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: directed and random traffic against a queue-based model.
module tb_sync_fifo_buf;

  localparam int DW    = 72;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          wclk;
  logic          wrst_n;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          rinc;
  logic          clr_err;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wfull;
  logic          rempty;
  logic          walmost_full;
  logic          ralmost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_PARITY_EN
  logic          par_err;
`endif

  sync_fifo_buf dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .wdata         (wdata),
    .winc          (winc),
    .rinc          (rinc),
    .clr_err       (clr_err),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
`ifdef FIFO_PARITY_EN
    ,
    .par_err       (par_err)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Reference model: the FIFO contents as a queue plus the expected registered outputs.
  logic [DW-1:0] model_q[$];
  logic          m_ov, m_un, m_rvalid, m_par, corrupt_head;
  logic [DW-1:0] m_rdata;
  int            wr_total;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ov         = 1'b0;
    m_un         = 1'b0;
    m_rvalid     = 1'b0;
    m_rdata      = '0;
    m_par        = 1'b0;
    corrupt_head = 1'b0;
    wr_total     = 0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
    int  n;
    logic was_full, was_empty;
    n         = model_q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (r && !was_empty) begin
      m_rdata      = model_q.pop_front();
      m_rvalid     = 1'b1;
      m_par        = corrupt_head;
      corrupt_head = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      m_par    = 1'b0;
    end
    if (w && !was_full) begin
      model_q.push_back(d);
      wr_total++;
    end
    if (clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (w && was_full)  m_ov = 1'b1;
    if (r && was_empty) m_un = 1'b1;
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("count",         DW'(count),         DW'(n));
    check("wfull",         DW'(wfull),         DW'(n == DEPTH));
    check("rempty",        DW'(rempty),        DW'(n == 0));
    check("walmost_full",  DW'(walmost_full),  DW'(n >= 120));
    check("ralmost_empty", DW'(ralmost_empty), DW'(n <= 8));
    check("rvalid",        DW'(rvalid),        DW'(m_rvalid));
    check("rdata",         rdata,              m_rdata);
    check("overflow",      DW'(overflow),      DW'(m_ov));
    check("underflow",     DW'(underflow),     DW'(m_un));
`ifdef FIFO_PARITY_EN
    check("par_err",       DW'(par_err),       DW'(m_par));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
    winc    = w;
    rinc    = r;
    wdata   = d;
    clr_err = clr;
    @(posedge wclk);
    model_edge(w, r, d, clr);
    @(negedge wclk);
    check_all();
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    wrst_n  = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
    wdata   = '0;
    model_reset();

    // Reset state, checked while reset is held and after release.
    repeat (2) @(negedge wclk);
    check_all();
    wrst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);

    // Fill to full with an index pattern, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    step(1'b1, 1'b0, DW'(8'hAA), 1'b0);

    // Full with both requests: read wins, write rejected.
    step(1'b1, 1'b1, DW'(8'hBB), 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Empty with both requests: write wins, read rejected.
    step(1'b1, 1'b1, DW'(8'hCC), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0);

    // Steady state at 64 entries with pointer wrap.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, rand_word(), 1'b0);

    // Random traffic: write-biased, then read-biased, to hit both ends.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30, rand_word(),
           $urandom_range(0, 99) < 5);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75, rand_word(),
           $urandom_range(0, 99) < 5);

    // Drain, then clr_err coinciding with a read of an empty FIFO.
    for (int i = 0; i < DEPTH + 4 && model_q.size() > 0; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

`ifdef FIFO_PARITY_EN
    // Flip one data bit in the oldest stored word; the read must flag it, the next must not.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    begin
      int idx;
      idx = (wr_total - model_q.size()) % DEPTH;
      dut.mem_q[idx][3] = ~dut.mem_q[idx][3];
      model_q[0][3]     = ~model_q[0][3];
      corrupt_head      = 1'b1;
    end
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
`endif

    // Asynchronous reset in the middle of a cycle at count 50.
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    winc = 1'b0;
    #2 wrst_n = 1'b0;
    #1;
    model_reset();
    check("async_count",  DW'(count),  DW'(0));
    check("async_rempty", DW'(rempty), DW'(1));
    @(negedge wclk);
    check_all();
    wrst_n = 1'b1;
    step(1'b1, 1'b0, DW'(8'h5A), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
